// File: rtl/otf_digit_sequencer.sv
// rtl/otf_digit_sequencer.sv - sequences a radix-4 on-the-fly converter from an online digit stream
// Optional illegal-digit checking enabled by defining OTF_SEQ_DIGIT_CHECK_EN.
module otf_digit_sequencer #(
  parameter int NO_OF_DIGITS = 8,
  parameter int ONLINE_DELAY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_digit,
  output logic                    conv_clr,
  output logic                    conv_en,
  output logic [2:0]              conv_digit,
  input  logic [NO_OF_DIGITS-1:0] conv_q,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [NO_OF_DIGITS-1:0] res_data,
  output logic                    err_digit
);

  localparam int N_CONV = NO_OF_DIGITS / 2;
  localparam int SKIP_W = (ONLINE_DELAY > 1) ? $clog2(ONLINE_DELAY + 1) : 1;
  localparam int CNT_W  = $clog2(N_CONV + 1);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((ONLINE_DELAY > 0) ? ONLINE_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0]  CONV_LAST = CNT_W'(N_CONV - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    SKIP    = 3'd2,
    CONVERT = 3'd3,
    DRAIN   = 3'd4,
    CAPTURE = 3'd5,
    OUTPUT  = 3'd6
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [SKIP_W-1:0]   skip_cnt;
  logic [CNT_W-1:0]    dig_cnt;
  logic                en_q;
  logic [2:0]          digit_q;
  logic [2:0]          fwd_digit;
  logic                accept;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        state_next = (ONLINE_DELAY > 0) ? SKIP : CONVERT;
      end
      SKIP: begin
        if (accept && (skip_cnt == SKIP_LAST)) state_next = CONVERT;
      end
      CONVERT: begin
        if (accept && (dig_cnt == CONV_LAST)) state_next = DRAIN;
      end
      DRAIN: begin
        state_next = CAPTURE;
      end
      CAPTURE: begin
        state_next = OUTPUT;
      end
      OUTPUT: begin
        if (res_ready) state_next = start ? CLEAR : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // res_valid is exactly "in OUTPUT": it rises after CAPTURE and drops on the handshake edge.
  always_comb begin
    busy      = 1'b1;
    in_ready  = 1'b0;
    conv_clr  = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE:    busy      = 1'b0;
      CLEAR:   conv_clr  = 1'b1;
      SKIP:    in_ready  = 1'b1;
      CONVERT: in_ready  = 1'b1;
      OUTPUT:  res_valid = 1'b1;
      default: ;
    endcase
  end

`ifdef OTF_SEQ_DIGIT_CHECK_EN
  logic illegal;
  logic err_q;

  assign illegal   = (in_digit == 3'b100);
  assign fwd_digit = illegal ? 3'b000 : in_digit;
  assign err_digit = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state == CLEAR) begin
      err_q <= 1'b0;
    end else if ((state == CONVERT) && accept && illegal) begin
      err_q <= 1'b1;
    end
  end
`else
  assign fwd_digit = in_digit;
  assign err_digit = 1'b0;
`endif

  // The converter enable is registered so each accepted digit yields exactly one pulse a cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      skip_cnt <= '0;
      dig_cnt  <= '0;
      en_q     <= 1'b0;
      digit_q  <= 3'b000;
      res_data <= '0;
    end else begin
      en_q    <= 1'b0;
      digit_q <= 3'b000;
      case (state)
        CLEAR: begin
          skip_cnt <= '0;
          dig_cnt  <= '0;
        end
        SKIP: begin
          if (accept) skip_cnt <= skip_cnt + SKIP_W'(1);
        end
        CONVERT: begin
          if (accept) begin
            dig_cnt <= dig_cnt + CNT_W'(1);
            en_q    <= 1'b1;
            digit_q <= fwd_digit;
          end
        end
        CAPTURE: begin
          res_data <= conv_q;
        end
        default: ;
      endcase
    end
  end

  assign conv_en    = en_q;
  assign conv_digit = digit_q;

endmodule

// File: tb/tb_otf_digit_sequencer.sv
// tb/tb_otf_digit_sequencer.sv - directed bench for otf_digit_sequencer
module tb_otf_digit_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_digit;
  logic       conv_clr;
  logic       conv_en;
  logic [2:0] conv_digit;
  logic [7:0] conv_q;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       err_digit;

  logic       start_z;
  logic       busy_z;
  logic       in_ready_z;
  logic       conv_clr_z;
  logic       conv_en_z;
  logic [2:0] conv_digit_z;
  logic [7:0] conv_q_z;
  logic       res_valid_z;
  logic       res_ready_z;
  logic [7:0] res_data_z;
  logic       err_digit_z;

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;
  int clr_cnt  = 0;
  logic [2:0] en_log [64];
  logic [2:0] stream [6];

  always #5 clk = ~clk;

  otf_digit_sequencer #(.NO_OF_DIGITS(8), .ONLINE_DELAY(2)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit),
    .conv_clr(conv_clr), .conv_en(conv_en), .conv_digit(conv_digit), .conv_q(conv_q),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .err_digit(err_digit)
  );

  otf_digit_sequencer #(.NO_OF_DIGITS(8), .ONLINE_DELAY(0)) dut_z (
    .clk(clk), .reset(reset), .start(start_z), .busy(busy_z),
    .in_valid(in_valid), .in_ready(in_ready_z), .in_digit(in_digit),
    .conv_clr(conv_clr_z), .conv_en(conv_en_z), .conv_digit(conv_digit_z), .conv_q(conv_q_z),
    .res_valid(res_valid_z), .res_ready(res_ready_z), .res_data(res_data_z), .err_digit(err_digit_z)
  );

  assign conv_q_z = 8'h00;

  // Simple radix-4 accumulator standing in for the converter: q = 4*q + digit.
  always @(posedge clk) begin
    if (reset || conv_clr) conv_q <= 8'h00;
    else if (conv_en) conv_q <= {conv_q[5:0], 2'b00} + {{5{conv_digit[2]}}, conv_digit};
  end

  always @(negedge clk) begin
    if (conv_en) begin
      if (en_cnt < 64) en_log[en_cnt] = conv_digit;
      en_cnt++;
    end
    if (conv_clr) clr_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_conv(input bit gaps, output int cycles);
    int idx;
    bit acc;
    bit par;
    idx = 0;
    par = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    while (cycles < 100) begin
      in_valid = (idx < 6) && (!gaps || par);
      in_digit = (idx < 6) ? stream[idx] : 3'b000;
      if (res_valid) break;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cycles++;
      par = ~par;
    end
    in_valid = 1'b0;
  endtask

  task automatic verify_run(input string tag, input int en0, input int clr0, input int cycles,
                            input int exp_cycles, input logic [2:0] d2, input logic [7:0] exp_res);
    check_eq({tag, "_latency"}, cycles, exp_cycles);
    check_eq({tag, "_res_valid"}, res_valid, 1);
    check_eq({tag, "_clr_pulses"}, clr_cnt - clr0, 1);
    check_eq({tag, "_en_pulses"}, en_cnt - en0, 4);
    check_eq({tag, "_dig0"}, en_log[en0], 3'b001);
    check_eq({tag, "_dig1"}, en_log[en0 + 1], 3'b010);
    check_eq({tag, "_dig2"}, en_log[en0 + 2], d2);
    check_eq({tag, "_dig3"}, en_log[en0 + 3], 3'b011);
    check_eq({tag, "_res_data"}, res_data, exp_res);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int en0;
    int clr0;
    bit stable;
    logic [2:0] exp_d2;
    logic       exp_err;
    logic [7:0] exp_res;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_digit = 3'b000;
    res_ready = 1'b0; start_z = 1'b0; res_ready_z = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_conv_clr", conv_clr, 0);
    check_eq("rst_conv_en", conv_en, 0);
    check_eq("rst_conv_digit", conv_digit, 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_res_data", res_data, 0);
    check_eq("rst_err_digit", err_digit, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Continuous stream 0,0,1,2,-1,3: two dropped, result 0x5F.
    stream = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b111, 3'b011};
    en0 = en_cnt; clr0 = clr_cnt;
    run_conv(1'b0, cyc);
    verify_run("cont", en0, clr0, cyc, 10, 3'b111, 8'h5F);
    consume();
    check_eq("idle_after_hs", busy, 0);

    // Same stream with alternate-cycle gaps: five extra cycles.
    en0 = en_cnt; clr0 = clr_cnt;
    run_conv(1'b1, cyc);
    verify_run("gaps", en0, clr0, cyc, 15, 3'b111, 8'h5F);

    // Hold in OUTPUT with a stray start pulse.
    clr0 = clr_cnt;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (!res_valid || res_data !== 8'h5F) stable = 1'b0;
    end
    check_eq("hold_stable", stable, 1);
    check_eq("hold_no_clr", clr_cnt - clr0, 0);

    // Handshake with start: straight into CLEAR.
    res_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0; start = 1'b0;
    check_eq("b2b_conv_clr", conv_clr, 1);
    check_eq("b2b_res_valid", res_valid, 0);
    check_eq("b2b_busy", busy, 1);

    // Two skips and two converted digits, then reset mid-CONVERT.
    in_valid = 1'b1; in_digit = 3'b001;
    repeat (5) @(posedge clk);
    #1;
    check_eq("mid_conv_en", conv_en, 1);
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_in_ready", in_ready, 0);
    check_eq("abort_conv_en", conv_en, 0);
    check_eq("abort_res_valid", res_valid, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    en0 = en_cnt; clr0 = clr_cnt;
    run_conv(1'b0, cyc);
    verify_run("after_abort", en0, clr0, cyc, 10, 3'b111, 8'h5F);
    consume();

    // Illegal -4 as the third converted digit.
`ifdef OTF_SEQ_DIGIT_CHECK_EN
    exp_d2 = 3'b000; exp_err = 1'b1; exp_res = 8'h63;
`else
    exp_d2 = 3'b100; exp_err = 1'b0; exp_res = 8'h53;
`endif
    stream = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b011};
    en0 = en_cnt; clr0 = clr_cnt;
    run_conv(1'b0, cyc);
    verify_run("illegal", en0, clr0, cyc, 10, exp_d2, exp_res);
    check_eq("err_sticky", err_digit, exp_err);
    consume();
    check_eq("err_in_idle", err_digit, exp_err);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("err_clr_pulse", conv_clr, 1);
    @(posedge clk); #1;
    check_eq("err_cleared", err_digit, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // ONLINE_DELAY=0 instance: ready right after CLEAR, first digit forwarded.
    start_z = 1'b1;
    @(posedge clk); #1;
    start_z = 1'b0;
    check_eq("z_conv_clr", conv_clr_z, 1);
    check_eq("z_ready_in_clear", in_ready_z, 0);
    @(posedge clk); #1;
    check_eq("z_ready_after_clear", in_ready_z, 1);
    in_valid = 1'b1; in_digit = 3'b010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("z_conv_en", conv_en_z, 1);
    check_eq("z_conv_digit", conv_digit_z, 3'b010);
    check_eq("z_main_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/otf_digit_sequencer.md
# otf_digit_sequencer

Controller that sequences one radix-4 on-the-fly converter for an online arithmetic unit. It:
- accepts a signed-digit stream (digits in {-3..3}) from the online unit over a valid/ready handshake;
- discards the leading online-delay digits;
- clears the converter, feeds it exactly one digit per enable pulse, and captures the converted result into a valid/ready output register.

It sits between the online operator's digit output and the converter's digit input.

## Interface
Parameters:
- NO_OF_DIGITS, 8, converted result width in bits (2 bits per radix-4 digit; must be even, ≥4)
- ONLINE_DELAY, 2, number of leading stream digits dropped before conversion (0..7)

Ports:
- clk  input  1  rising-edge clock; one clock domain
- reset  input  1  synchronous, active-high reset
- start  input  1  request a new conversion; sampled only in IDLE or OUTPUT
- busy  output  1  high in every state except IDLE
- in_valid  input  1  digit stream valid
- in_ready  output  1  digit accepted on clk edge when in_valid & in_ready
- in_digit  input  3  signed two's-complement digit
- conv_clr  output  1  one-cycle converter clear pulse
- conv_en  output  1  converter shift enable, one cycle per forwarded digit
- conv_digit  output  3  digit to converter; 3'b000 when conv_en=0
- conv_q  input  NO_OF_DIGITS  converter Q register
- res_valid  output  1  result available
- res_ready  input  1  result consumed on clk edge when res_valid & res_ready
- res_data  output  NO_OF_DIGITS  captured result
- err_digit  output  1  sticky illegal-digit flag

## Operation
The block is an FSM with states IDLE, CLEAR, SKIP, CONVERT, DRAIN, CAPTURE and OUTPUT. Counters are a skip count (width for ONLINE_DELAY) and a digit count (width for NO_OF_DIGITS/2).

State behaviour:
- IDLE: in_ready=0. start=1 → CLEAR.
- CLEAR: conv_clr=1 for this cycle. Skip count and digit count are zeroed, and err_digit is cleared. Next state is SKIP if ONLINE_DELAY>0, else CONVERT.
- SKIP: in_ready=1. Each accepted digit increments the skip count and is dropped. When the ONLINE_DELAY-th digit is accepted → CONVERT.
- CONVERT: in_ready=1. Each accepted digit is registered: next cycle conv_en=1 and conv_digit=that digit. The digit count increments on each accept. When the NO_OF_DIGITS/2-th digit is accepted → DRAIN.
- DRAIN: in_ready=0. The final conv_en pulse is active in this cycle → CAPTURE.
- CAPTURE: conv_q now holds the final value. At the end of the cycle, res_data ← conv_q and res_valid ← 1 → OUTPUT.
- OUTPUT: res_valid held at 1 and res_data held stable until res_ready=1.
  - On handshake: if start=1 in the same cycle → CLEAR, else → IDLE.
  - res_valid drops on the handshake edge.

Rules:
- start is ignored in CLEAR, SKIP, CONVERT, DRAIN and CAPTURE.
- in_valid without in_ready has no effect; digits are never lost while in_ready=1.
- Gaps in in_valid stall the count. conv_en pulses only for accepted digits, so no zero digits are inserted into the converter.
- Illegal digit 3'b100 (-4): see Configuration.
- res_data keeps its last captured value outside OUTPUT.

## Timing
Reset values: FSM=IDLE, busy=0, in_ready=0, conv_clr=0, conv_en=0, conv_digit=0, res_valid=0, res_data=0, err_digit=0, both counters 0.

Cycle-level timing:
- Synchronous reset in any state returns to IDLE next edge and aborts the conversion. No conv_clr is issued; the converter is reset by the same reset.
- start accepted at edge t: conv_clr=1 in cycle t+1, and in_ready=1 from cycle t+2.
- Digit accepted at edge k: conv_en=1 in cycle k+1, converter updates at edge k+2.
- Last digit accepted at edge L: DRAIN in cycle L+1, CAPTURE in cycle L+2, res_valid=1 from edge L+3.
- Minimum conversion with continuous in_valid: 2 + ONLINE_DELAY + NO_OF_DIGITS/2 + 2 cycles from start to res_valid. Default parameters give 10 cycles.
- Back-to-back: a res handshake with start=1 in the same cycle gives conv_clr in the next cycle, with no IDLE cycle.

## Configuration
- Macro OTF_SEQ_DIGIT_CHECK_EN.
- Defined:
  - in_digit=3'b100, when accepted in CONVERT, sets err_digit, which stays set until the next CLEAR.
  - That digit is forwarded as 3'b000 and still counted.
  - Digits dropped in SKIP are not checked.
- Undefined: err_digit is tied 0 and every digit is forwarded unchanged.

## Test plan
- Defaults, start, continuous digits 0,0,1,2,-1,3: conv_clr once; 4 conv_en pulses carrying 1,2,-1,3; res_valid at cycle 10 after start; res_data = conv_q sampled in CAPTURE.
- Same stream with in_valid low on alternate cycles: conv_en count stays 4, none with digit 0 inserted; res_valid delayed by the gap count.
- Hold res_ready=0 for 5 cycles in OUTPUT, pulse start meanwhile: res_valid/res_data stable, no conv_clr. Then res_ready=1 with start=1: conv_clr in the next cycle, res_valid=0.
- Assert reset during CONVERT after 2 digits: next cycle busy=0, in_ready=0, conv_en=0, res_valid=0. A new start requires the full digit count again.
- With OTF_SEQ_DIGIT_CHECK_EN, send -4 as 3rd converted digit: err_digit=1 from the next cycle, conv_digit=0 for that pulse; err_digit clears on the next CLEAR.
- ONLINE_DELAY=0: in_ready high directly after CLEAR; first accepted digit appears on conv_digit.
